// File: rtl/jt51_acc_seq_if.sv
// rtl/jt51_acc_seq_if.sv - stereo sample handoff between the slot sequencer and its consumer
interface jt51_acc_seq_if;
  logic signed [15:0] sample_l;
  logic signed [15:0] sample_r;
  logic               sample_valid;
  logic               sample_ready;

  modport master (
    output sample_l,
    output sample_r,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_l,
    input  sample_r,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/jt51_acc_seq.sv
// rtl/jt51_acc_seq.sv - JT51 operator slot sequencer, RL enables and per-frame sample capture
module jt51_acc_seq #(
  parameter logic [4:0] LATCH_SLOT = 5'd23
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_cen,
  input  logic               i_cfg_we,
  input  logic [2:0]         i_cfg_ch,
  input  logic [1:0]         i_cfg_rl,
  output logic [4:0]         o_slot,
  output logic               o_zero,
  output logic               o_op31_acc,
  output logic [1:0]         o_rl,
  input  logic signed [15:0] i_left_in,
  input  logic signed [15:0] i_right_in,
  output logic               o_overrun,
  input  logic               i_ovr_clr,
  jt51_acc_seq_if.master     smp
);

  logic [4:0]         r_slot;
  logic               r_zero;
  logic               r_op31;
  logic [1:0]         r_rl;
  logic [1:0]         r_rl_cfg [8];
  logic               r_wrapped;
  logic               r_primed;
  logic signed [15:0] r_sample_l;
  logic signed [15:0] r_sample_r;
  logic               r_valid;
  logic               r_overrun;

  logic [4:0]         w_slot_nx;
  logic               w_capture;
  logic               w_xfer;

  assign w_slot_nx = r_slot + 5'd1;
  // The first frame after reset sums garbage, so capture waits for primed.
  assign w_capture = i_cen & r_primed & (w_slot_nx == LATCH_SLOT);
  assign w_xfer    = r_valid & smp.sample_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot     <= 5'd31;
      r_zero     <= 1'b0;
      r_op31     <= 1'b0;
      r_rl       <= 2'b00;
      r_wrapped  <= 1'b0;
      r_primed   <= 1'b0;
      r_sample_l <= '0;
      r_sample_r <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
      for (int i = 0; i < 8; i++) r_rl_cfg[i] <= 2'b00;
    end else begin
      if (i_cen) begin
        r_slot <= w_slot_nx;
        r_zero <= (w_slot_nx == 5'd0);
        r_op31 <= (w_slot_nx == 5'd31);
        r_rl   <= r_rl_cfg[w_slot_nx[2:0]];
        if (w_slot_nx == 5'd0) begin
          r_wrapped <= 1'b1;
          if (r_wrapped) r_primed <= 1'b1;
        end
      end

      if (i_cfg_we) r_rl_cfg[i_cfg_ch] <= i_cfg_rl;

      if (w_capture) begin
        r_sample_l <= i_left_in;
        r_sample_r <= i_right_in;
        r_valid    <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end

      // A new overrun beats a simultaneous clear.
      if (w_capture & r_valid & ~smp.sample_ready) r_overrun <= 1'b1;
      else if (i_ovr_clr)                           r_overrun <= 1'b0;
    end
  end

  assign o_slot           = r_slot;
  assign o_zero           = r_zero;
  assign o_op31_acc       = r_op31;
  assign o_rl             = r_rl;
  assign o_overrun        = r_overrun;
  assign smp.sample_l     = r_sample_l;
  assign smp.sample_r     = r_sample_r;
  assign smp.sample_valid = r_valid;

endmodule

// File: tb/tb_jt51_acc_seq.sv
// tb/tb_jt51_acc_seq.sv - scoreboard bench for jt51_acc_seq
module tb_jt51_acc_seq;

  logic               clk = 1'b0;
  logic               rst;
  logic               cen;
  logic               cfg_we;
  logic [2:0]         cfg_ch;
  logic [1:0]         cfg_rl;
  logic [4:0]         slot;
  logic               zero;
  logic               op31_acc;
  logic [1:0]         rl;
  logic signed [15:0] left_in;
  logic signed [15:0] right_in;
  logic               overrun;
  logic               ovr_clr;

  jt51_acc_seq_if smp ();

  jt51_acc_seq #(.LATCH_SLOT(5'd23)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_cen      (cen),
    .i_cfg_we   (cfg_we),
    .i_cfg_ch   (cfg_ch),
    .i_cfg_rl   (cfg_rl),
    .o_slot     (slot),
    .o_zero     (zero),
    .o_op31_acc (op31_acc),
    .o_rl       (rl),
    .i_left_in  (left_in),
    .i_right_in (right_in),
    .o_overrun  (overrun),
    .i_ovr_clr  (ovr_clr),
    .smp        (smp.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state (what the spec says the DUT holds after the next edge)
  logic [4:0]  m_slot;
  logic [1:0]  m_cfg [8];
  bit          m_wrapped, m_primed, m_valid, m_ovr, m_known;
  // Expected DUT state right now, published for the monitor
  bit          e_valid, e_ovr, e_known;
  bit          last_cen = 1'b0;

  logic [8:0]  ctrl_q [$];
  logic [31:0] samp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: slot controls after every cen edge, handshake data on every transfer
  always @(negedge clk) begin
    logic [8:0]  ce;
    logic [31:0] se;
    if (last_cen) begin
      if (ctrl_q.size() == 0) chk("ctrl_queue_empty", 32'd1, 32'd0);
      else begin
        ce = ctrl_q.pop_front();
        chk("slot", {27'd0, slot}, {27'd0, ce[8:4]});
        chk("zero", {31'd0, zero}, {31'd0, ce[3]});
        chk("op31_acc", {31'd0, op31_acc}, {31'd0, ce[2]});
        chk("rl", {30'd0, rl}, {30'd0, ce[1:0]});
      end
    end
    last_cen = cen && !rst;
    if (e_known) begin
      chk("sample_valid", {31'd0, smp.sample_valid}, {31'd0, e_valid});
      chk("overrun", {31'd0, overrun}, {31'd0, e_ovr});
      if (smp.sample_valid && smp.sample_ready && !rst) begin
        if (samp_q.size() == 0) chk("sample_queue_empty", 32'd1, 32'd0);
        else begin
          se = samp_q.pop_front();
          chk("sample_l", {16'd0, smp.sample_l}, {16'd0, se[31:16]});
          chk("sample_r", {16'd0, smp.sample_r}, {16'd0, se[15:0]});
        end
      end
    end
  end

  // Apply one clock of stimulus, advance the model, wait to the next drive point
  task automatic step(input bit c);
    logic [4:0] nx;
    bit cap;
    cen = c;
    e_valid = m_valid;
    e_ovr   = m_ovr;
    e_known = m_known;
    if (rst) begin
      m_slot = 5'd31; m_wrapped = 0; m_primed = 0; m_valid = 0; m_ovr = 0; m_known = 1;
      for (int i = 0; i < 8; i++) m_cfg[i] = 2'b00;
      samp_q.delete();
    end else begin
      cap = 0;
      if (c) begin
        nx  = m_slot + 5'd1;
        cap = m_primed && (nx == 5'd23);
        ctrl_q.push_back({nx, nx == 5'd0, nx == 5'd31, m_cfg[nx[2:0]]});
        if (nx == 5'd0) begin
          if (m_wrapped) m_primed = 1;
          m_wrapped = 1;
        end
        m_slot = nx;
      end
      if (cfg_we) m_cfg[cfg_ch] = cfg_rl;
      if (cap) begin
        if (m_valid && !smp.sample_ready) begin
          void'(samp_q.pop_back());
          m_ovr = 1;
        end else if (ovr_clr) m_ovr = 0;
        samp_q.push_back({left_in, right_in});
        m_valid = 1;
      end else begin
        if (m_valid && smp.sample_ready) m_valid = 0;
        if (ovr_clr) m_ovr = 0;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic cap_with(input logic [15:0] l, input logic [15:0] r);
    int guard = 0;
    while (m_slot != 5'd22 && guard < 40) begin step(1); guard++; end
    left_in = l; right_in = r;
    step(1);
  endtask

  task automatic chk_reset;
    chk("rst_slot", {27'd0, slot}, 32'd31);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_op31", {31'd0, op31_acc}, 32'd0);
    chk("rst_rl", {30'd0, rl}, 32'd0);
    chk("rst_sample_l", {16'd0, smp.sample_l}, 32'd0);
    chk("rst_sample_r", {16'd0, smp.sample_r}, 32'd0);
    chk("rst_valid", {31'd0, smp.sample_valid}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    rst = 1; cen = 0; cfg_we = 0; cfg_ch = 0; cfg_rl = 0;
    left_in = 0; right_in = 0; ovr_clr = 0; smp.sample_ready = 0;
    m_slot = 5'd31; m_known = 0; m_valid = 0; m_ovr = 0; m_wrapped = 0; m_primed = 0;
    for (int i = 0; i < 8; i++) m_cfg[i] = 2'b00;
    step(0); step(0);
    rst = 0;
    chk_reset();

    // Free-running frame with all channels muted
    smp.sample_ready = 1;
    left_in = 16'sh1234; right_in = -16'sd5;
    repeat (32) step(1);

    // Config writes on idle cycles, then the frame holding the first capture (cen 56)
    cfg_we = 1; cfg_ch = 3'd3; cfg_rl = 2'b01; step(0);
    cfg_ch = 3'd6; cfg_rl = 2'b10; step(0);
    cfg_we = 0;
    repeat (32) step(1);
    left_in = 16'sh7fff; right_in = -16'sh8000;
    repeat (32) step(1);
    left_in = -16'sd1; right_in = 16'sd0;
    repeat (32) step(1);

    // Overrun: two captures with no consumer, then drain and clear
    smp.sample_ready = 0;
    cap_with(16'h0111, 16'h0222);
    cap_with(16'h0333, 16'h0444);
    step(0); step(0);
    smp.sample_ready = 1; step(0);
    smp.sample_ready = 0;
    ovr_clr = 1; step(0);
    ovr_clr = 0; step(0);

    // Overrun coinciding with a held clear: set wins for that edge
    cap_with(16'h0555, 16'h0666);
    ovr_clr = 1;
    cap_with(16'h0777, 16'h0888);
    step(0);
    ovr_clr = 0;
    smp.sample_ready = 1; step(0);
    step(0);

    // Capture coinciding with transfer: no overrun, new sample loads
    smp.sample_ready = 0;
    cap_with(16'h1111, 16'h2222);
    while (m_slot != 5'd22) step(1);
    smp.sample_ready = 1;
    left_in = 16'h3333; right_in = 16'h4444;
    step(1);
    step(0); step(0);

    // Slow cen: one slot per three clocks, config writes on non-cen cycles
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (i == 5)  begin cfg_we = 1; cfg_ch = 3'd0; cfg_rl = 2'b11; end
      if (i == 40) begin cfg_we = 1; cfg_ch = 3'd3; cfg_rl = 2'b10; end
      step(0);
      cfg_we = 0;
      step(0);
    end

    // Reset at slot 17 with a sample pending, then the 56-cen priming again
    smp.sample_ready = 0;
    cap_with(16'h5a5a, 16'ha5a5);
    while (m_slot != 5'd17) step(1);
    rst = 1; step(1);
    rst = 0;
    chk_reset();
    smp.sample_ready = 1;
    left_in = 16'sh0abc; right_in = -16'sd300;
    repeat (60) step(1);
    step(0); step(0);

    chk("samples_left", samp_q.size(), 32'd0);
    chk("ctrl_left", ctrl_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jt51_acc_seq.md
# jt51_acc_seq

Slot sequencer and output-sample controller for the JT51 operator accumulator. It runs the 32-slot operator frame counter and drives the accumulator's `zero`, `op31_acc` and `rl` controls in slot alignment. It holds the per-channel left/right enable configuration. Once per frame it captures the accumulator's exact stereo sums and hands them to the downstream sample consumer over a valid/ready handshake, with overrun detection.

## Interface
- `LATCH_SLOT`, default 5'd23: slot at whose entry `left_in`/`right_in` are captured. This is one slot after the accumulator's internally delayed frame boundary.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `cen` in 1: slot clock enable. One slot advances per `cen` cycle.
- `cfg_we` in 1: RL configuration write strobe. Honoured regardless of `cen`.
- `cfg_ch` in 3: channel index for the write.
- `cfg_rl` in 2: {right, left} enable for `cfg_ch`.
- `slot` out 5: current operator slot.
- `zero` out 1: frame-start pulse, high while `slot`==0.
- `op31_acc` out 1: high while `slot`==31, the noise-substitution slot.
- `rl` out 2: RL enable of channel `slot[2:0]`.
- `left_in` in 16 signed: exact left sum from the accumulator.
- `right_in` in 16 signed: exact right sum from the accumulator.
- `sample_l` out 16 signed: captured left sample.
- `sample_r` out 16 signed: captured right sample.
- `sample_valid` out 1: captured sample pending.
- `sample_ready` in 1: consumer accepts the sample.
- `overrun` out 1: sticky flag, set when a pending sample is overwritten.
- `ovr_clr` in 1: clears `overrun`.

## Operation
- **Slot counter**
  - 5-bit register. Reset value 31.
  - On each `cen` cycle: `slot <= slot+1`, wrapping 31→0.
  - No advance when `cen`=0.
- **Control outputs**
  - All registered and updated with `slot`.
  - `zero` = (new slot==0).
  - `op31_acc` = (new slot==31).
  - `rl` = `rl_cfg[new_slot[2:0]]`.
- **RL configuration**
  - Eight 2-bit registers, all reset to 2'b00 (muted).
  - `cfg_we` writes `rl_cfg[cfg_ch] <= cfg_rl`.
  - A write to the channel being output in the same cycle takes effect on the next slot advance. The `rl` output currently held is not changed retroactively.
- **Priming**
  - A `primed` flag resets to 0.
  - A frame count increments on each slot wrap to 0. `primed` sets on the second wrap, i.e. the start of frame 1.
  - This discards the first accumulator dump, which sums pre-reset garbage.
- **Capture event**
  - Occurs on a `cen` cycle where `primed`=1 and the new slot == `LATCH_SLOT`.
  - Registers `left_in` → `sample_l` and `right_in` → `sample_r`, and sets `sample_valid`.
- **Handshake**
  - Transfer occurs when `sample_valid` and `sample_ready` are both high. `sample_valid` clears next cycle unless a capture happens in the same cycle.
  - `sample_l`/`sample_r` are stable while `sample_valid`=1 and no capture occurs.
- **Overrun**
  - Capture while `sample_valid`=1 and `sample_ready`=0: the new sample overwrites the old, `sample_valid` stays 1, and `overrun` sets.
  - Capture coinciding with transfer: the new sample loads, `sample_valid` stays 1, no overrun.
  - `ovr_clr` clears `overrun`. If set and clear happen in the same cycle, set wins.
- **Values**
  - Samples are passed through unmodified, 16-bit signed.
  - No saturation here; the accumulator already clamps.

## Timing
- Reset values:
  - `slot`=31
  - `zero`=0, `op31_acc`=0, `rl`=00
  - `sample_l`=`sample_r`=0
  - `sample_valid`=0, `overrun`=0
  - `primed`=0, all `rl_cfg`=00
- Reset mid-frame takes effect on the next edge regardless of `cen`. It aborts any pending sample without flagging overrun.
- First `cen` after reset: `slot`=0, `zero`=1.
- Frame period: 32 `cen` cycles.
- `zero` is high for exactly one `cen` period per frame. The same holds for `op31_acc`.
- First capture happens at the `LATCH_SLOT` entry of frame 1: the (32+`LATCH_SLOT`+1)th `cen` after reset, i.e. the 56th with the default.
- Capture latency: `sample_*` valid one clock after the `cen` edge that enters `LATCH_SLOT`.
- Config write to output latency: at most 1 slot after the channel's next appearance.
- `sample_ready` may be asserted at any time. It is ignored while `sample_valid`=0.

## Test plan
- Reset, then `cen` held high: `slot` runs 0..31 and wraps, `zero` is high only at slot 0, `op31_acc` only at slot 31, and `rl`=00 throughout.
- Write ch3=2'b01 and ch6=2'b10, then run one frame: `rl`=01 at slots 3,11,19,27, `rl`=10 at slots 6,14,22,30, and 00 elsewhere.
- `left_in`=16'sh1234, `right_in`=-16'sd5, `sample_ready`=1: first `sample_valid` appears after the 56th `cen` with `sample_l`=1234h and `sample_r`=FFFBh, then one capture every 32 `cen`.
- `sample_ready`=0 for two frames: the second capture overwrites the first and `overrun`=1. `ovr_clr` then clears it. Holding `ovr_clr` in the same cycle as a new overrun leaves `overrun`=1.
- `cen` toggling every 3rd clock: same slot sequence with the frame stretched to 96 clocks, and config writes on non-`cen` cycles still land.
- `rst` asserted at slot 17 with a sample pending: everything returns to reset values and the next capture comes again after 56 `cen`.
